dot_product_mac: RTL and testbench



---
 rtl/dot_product_mac_pkg.sv | 30 +++
 rtl/dot_product_datapath.sv | 99 +++++++++
 rtl/dot_product_mac.sv | 110 +++++++++++
 tb/tb_dot_product_mac.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dot_product_mac_pkg.sv
// Shared definitions for the 4x4 matrix multiplier dot-product engine.
// Holds the controller state encoding, default widths and the saturation
// limit helpers used by the datapath range check.
package dot_product_mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDone,
    StErr
  } state_e;

  localparam int unsigned DefaultW    = 16;
  localparam int unsigned DefaultFrac = 8;
  localparam int unsigned NumTerms    = 4;

  // k value at which all four terms are in the accumulator and the result is checked.
  localparam int unsigned KLast = NumTerms;

  // Largest positive value representable in a w-bit two's complement word.
  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a w-bit two's complement word.
  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/dot_product_datapath.sv
// Datapath for the dot-product engine: operand registers, k-indexed operand
// mux, single shared multiplier, 2W+2 accumulator and shift/saturate stage.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_clr                 synchronous clear of all registers (wins over others)
//   i_load                latch operands and zero the accumulator
//   i_acc                 accumulate A[i_k]*B[i_k]
//   i_finish              capture the saturated result
//   i_k                   term index for the operand mux
//   i_fila, i_columna     row of A / column of B, element k at [k*W +: W]
//   o_result              registered, saturated result
//   o_ovf                 combinational range flag for the current accumulator
module dot_product_datapath
  import dot_product_mac_pkg::*;
#(
  parameter int unsigned W    = DefaultW,
  parameter int unsigned FRAC = DefaultFrac
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic                i_acc,
  input  logic                i_finish,
  input  logic [1:0]          i_k,
  input  logic [4*W-1:0]      i_fila,
  input  logic [4*W-1:0]      i_columna,
  output logic signed [W-1:0] o_result,
  output logic                o_ovf
);

  localparam int unsigned AccW = 2 * W + 2;

  localparam logic signed [AccW-1:0] SatHi = AccW'(sat_hi(W));
  localparam logic signed [AccW-1:0] SatLo = AccW'(sat_lo(W));
  localparam logic signed [W-1:0]    ResHi = W'(sat_hi(W));
  localparam logic signed [W-1:0]    ResLo = W'(sat_lo(W));

  logic [4*W-1:0]         r_fila;
  logic [4*W-1:0]         r_columna;
  logic signed [AccW-1:0] r_acc;
  logic signed [W-1:0]    r_result;

  logic signed [W-1:0]    w_a;
  logic signed [W-1:0]    w_b;
  logic signed [2*W-1:0]  w_prod;
  logic signed [AccW-1:0] w_prod_ext;
  logic signed [AccW-1:0] w_shift;
  logic signed [W-1:0]    w_sat;
  logic                   w_ovf;

  assign w_a        = r_fila[W*i_k +: W];
  assign w_b        = r_columna[W*i_k +: W];
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = AccW'(w_prod);
  // Arithmetic shift: truncation toward minus infinity.
  assign w_shift    = r_acc >>> FRAC;

  always_comb begin
    w_ovf = 1'b0;
    w_sat = W'(w_shift);
    if (w_shift > SatHi) begin
      w_ovf = 1'b1;
      w_sat = ResHi;
    end else if (w_shift < SatLo) begin
      w_ovf = 1'b1;
      w_sat = ResLo;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fila    <= '0;
      r_columna <= '0;
      r_acc     <= '0;
      r_result  <= '0;
    end else if (i_clr) begin
      r_fila    <= '0;
      r_columna <= '0;
      r_acc     <= '0;
      r_result  <= '0;
    end else begin
      if (i_load) begin
        r_fila    <= i_fila;
        r_columna <= i_columna;
        r_acc     <= '0;
      end else if (i_acc) begin
        r_acc <= r_acc + w_prod_ext;
      end
      if (i_finish) begin
        r_result <= w_sat;
      end
    end
  end

  assign o_result = r_result;
  assign o_ovf    = w_ovf;

endmodule

// File: rtl/dot_product_mac.sv
// Sequential signed fixed-point dot-product engine: computes
// sum_k A[k]*B[k] for k = 0..3 with one shared multiplier, then shifts by
// FRAC and saturates to W bits.
// Ports:
//   CLK, MasterReset_n   clock, asynchronous active-low reset
//   ResetCalculo         synchronous clear back to idle (ignores enable)
//   EnableCalculo        clock enable for all state
//   StartCalculo         start request, honoured only in idle
//   FilaA, ColumnaB      operand vectors, element k at [k*W +: W]
//   Resultado            saturated result
//   Listo                result valid (level)
//   Error                overflow/underflow occurred (level)
module dot_product_mac
  import dot_product_mac_pkg::*;
#(
  parameter int unsigned W    = DefaultW,
  parameter int unsigned FRAC = DefaultFrac
) (
  input  logic                CLK,
  input  logic                MasterReset_n,
  input  logic                ResetCalculo,
  input  logic                EnableCalculo,
  input  logic                StartCalculo,
  input  logic [4*W-1:0]      FilaA,
  input  logic [4*W-1:0]      ColumnaB,
  output logic signed [W-1:0] Resultado,
  output logic                Listo,
  output logic                Error
);

  state_e     r_state;
  state_e     w_state_d;
  logic [2:0] r_k;
  logic [2:0] w_k_d;
  logic       w_load;
  logic       w_acc;
  logic       w_finish;
  logic       w_ovf;

  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    w_load    = 1'b0;
    w_acc     = 1'b0;
    w_finish  = 1'b0;
    if (ResetCalculo) begin
      w_state_d = StIdle;
      w_k_d     = '0;
    end else if (EnableCalculo) begin
      unique case (r_state)
        StIdle: begin
          if (StartCalculo) begin
            w_load    = 1'b1;
            w_k_d     = '0;
            w_state_d = StMac;
          end
        end
        StMac: begin
          // One extra MAC cycle after the last term registers the checked result.
          if (r_k == 3'(KLast)) begin
            w_finish  = 1'b1;
            w_k_d     = '0;
            w_state_d = w_ovf ? StErr : StDone;
          end else begin
            w_acc = 1'b1;
            w_k_d = r_k + 3'd1;
          end
        end
        StDone, StErr: begin
          w_state_d = r_state;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge MasterReset_n) begin
    if (!MasterReset_n) begin
      r_state <= StIdle;
      r_k     <= '0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
    end
  end

  dot_product_datapath #(
    .W   (W),
    .FRAC(FRAC)
  ) u_datapath (
    .i_clk    (CLK),
    .i_rst_n  (MasterReset_n),
    .i_clr    (ResetCalculo),
    .i_load   (w_load),
    .i_acc    (w_acc),
    .i_finish (w_finish),
    .i_k      (r_k[1:0]),
    .i_fila   (FilaA),
    .i_columna(ColumnaB),
    .o_result (Resultado),
    .o_ovf    (w_ovf)
  );

  // Mutually exclusive by construction: decoded from a single state register.
  assign Listo = (r_state == StDone);
  assign Error = (r_state == StErr);

endmodule

// File: tb/tb_dot_product_mac.sv
module tb_dot_product_mac;

  localparam int W = 16;

  logic                CLK = 1'b0;
  logic                MasterReset_n;
  logic                ResetCalculo;
  logic                EnableCalculo;
  logic                StartCalculo;
  logic [4*W-1:0]      FilaA;
  logic [4*W-1:0]      ColumnaB;
  logic signed [W-1:0] Resultado;
  logic                Listo;
  logic                Error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  dot_product_mac #(
    .W   (16),
    .FRAC(8)
  ) dut (
    .CLK          (CLK),
    .MasterReset_n(MasterReset_n),
    .ResetCalculo (ResetCalculo),
    .EnableCalculo(EnableCalculo),
    .StartCalculo (StartCalculo),
    .FilaA        (FilaA),
    .ColumnaB     (ColumnaB),
    .Resultado    (Resultado),
    .Listo        (Listo),
    .Error        (Error)
  );

  function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs,
             $signed(exp), exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_listo, input logic exp_err,
                           input logic [15:0] exp_res);
    check($sformatf("%s.listo", tag), {15'd0, Listo}, {15'd0, exp_listo});
    check($sformatf("%s.error", tag), {15'd0, Error}, {15'd0, exp_err});
    check($sformatf("%s.res", tag), Resultado, exp_res);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Start sampled on the next rising edge (edge t); operands scrambled afterwards.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    FilaA        = a;
    ColumnaB     = b;
    StartCalculo = 1'b1;
    tick(1);
    StartCalculo = 1'b0;
    FilaA        = ~a;
    ColumnaB     = ~b;
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [15:0] exp_res, input logic exp_listo, input logic exp_err);
    start_op(a, b);
    tick(4);
    check($sformatf("%s.t4_listo", tag), {15'd0, Listo}, 16'd0);
    check($sformatf("%s.t4_error", tag), {15'd0, Error}, 16'd0);
    tick(1);
    check_all($sformatf("%s.t5", tag), exp_listo, exp_err, exp_res);
  endtask

  task automatic clear_op(input string tag);
    ResetCalculo = 1'b1;
    tick(1);
    ResetCalculo = 1'b0;
    check_all(tag, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    MasterReset_n = 1'b0;
    ResetCalculo  = 1'b0;
    EnableCalculo = 1'b1;
    StartCalculo  = 1'b0;
    FilaA         = '0;
    ColumnaB      = '0;
    tick(2);
    check_all("reset", 1'b0, 1'b0, 16'd0);
    MasterReset_n = 1'b1;
    tick(1);
    check_all("idle", 1'b0, 1'b0, 16'd0);

    // 1.0,2.0,3.0,4.0 dot 1.0 each = 10.0 -> 2560
    run_op("basic", pack4(256, 512, 768, 1024), pack4(256, 256, 256, 256), 16'd2560, 1'b1, 1'b0);

    // Listo and Resultado hold while Start toggles
    for (int i = 0; i < 10; i++) begin
      StartCalculo = i[0];
      FilaA        = pack4(i, 7, -3, 100);
      tick(1);
      check_all($sformatf("hold%0d", i), 1'b1, 1'b0, 16'd2560);
    end
    StartCalculo = 1'b0;
    clear_op("hold_clear");

    run_op("neg", pack4(-384, 0, 0, 0), pack4(256, 0, 0, 0), 16'hFE80, 1'b1, 1'b0);
    clear_op("neg_clear");
    run_op("trunc_pos", pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 16'd0, 1'b1, 1'b0);
    clear_op("trunc_pos_clear");
    run_op("trunc_neg", pack4(-1, 0, 0, 0), pack4(1, 0, 0, 0), 16'hFFFF, 1'b1, 1'b0);
    clear_op("trunc_neg_clear");

    run_op("ovf_pos", pack4(25600, 25600, 25600, 25600), pack4(25600, 25600, 25600, 25600),
           16'h7FFF, 1'b0, 1'b1);
    clear_op("ovf_pos_clear");
    run_op("ovf_neg", pack4(25600, 25600, 25600, 25600), pack4(-25600, -25600, -25600, -25600),
           16'h8000, 1'b0, 1'b1);
    clear_op("ovf_neg_clear");

    // Enable low for 3 edges mid-MAC, Start held high during MAC -> Listo at t+8
    start_op(pack4(256, 512, 768, 1024), pack4(256, 256, 256, 256));
    tick(1);
    StartCalculo  = 1'b1;
    tick(1);
    EnableCalculo = 1'b0;
    tick(3);
    check_all("stall_frozen", 1'b0, 1'b0, 16'd0);
    EnableCalculo = 1'b1;
    tick(1);
    StartCalculo  = 1'b0;
    tick(1);
    check_all("stall_t7", 1'b0, 1'b0, 16'd0);
    tick(1);
    check_all("stall_t8", 1'b1, 1'b0, 16'd2560);
    clear_op("stall_clear");

    // ResetCalculo sampled at t+2 aborts the operation
    start_op(pack4(256, 512, 768, 1024), pack4(256, 256, 256, 256));
    tick(1);
    ResetCalculo = 1'b1;
    tick(1);
    ResetCalculo = 1'b0;
    check_all("abort_t2", 1'b0, 1'b0, 16'd0);
    tick(6);
    check_all("abort_quiet", 1'b0, 1'b0, 16'd0);
    run_op("after_abort", pack4(-384, 0, 0, 0), pack4(256, 0, 0, 0), 16'hFE80, 1'b1, 1'b0);

    // Asynchronous master reset from DONE with a nonzero result
    #2 MasterReset_n = 1'b0;
    #1 check_all("mrst_done", 1'b0, 1'b0, 16'd0);
    tick(1);
    MasterReset_n = 1'b1;
    tick(1);

    // Asynchronous master reset mid-MAC, then a clean full-latency run
    start_op(pack4(256, 512, 768, 1024), pack4(256, 256, 256, 256));
    tick(2);
    #2 MasterReset_n = 1'b0;
    #1 check_all("mrst_mac", 1'b0, 1'b0, 16'd0);
    tick(1);
    MasterReset_n = 1'b1;
    tick(1);
    check_all("mrst_idle", 1'b0, 1'b0, 16'd0);
    run_op("after_mrst", pack4(256, 512, 768, 1024), pack4(256, 256, 256, 256), 16'd2560, 1'b1,
           1'b0);
    clear_op("final_clear");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
